// File: rtl/video_timing.sv
// Raster timing generator: H/V pixel counters advanced by PIX_CE, with registered
// blank/sync decodes, line/VBL strobes and a field toggle.
module video_timing #(
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 256,
    parameter int HS_START = 288,
    parameter int HS_END   = 320,
    parameter int V_TOTAL  = 264,
    parameter int V_ACTIVE = 224,
    parameter int VS_START = 240,
    parameter int VS_END   = 244
) (
    input  logic       CLK_24M,
    input  logic       RESET,
    input  logic       PIX_CE,
    output logic [8:0] HCNT,
    output logic [8:0] VCNT,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       LINE_START,
    output logic       VBL_START,
    output logic       FIELD
);

    if (!(H_ACTIVE < HS_START && HS_START < HS_END && HS_END <= H_TOTAL &&
          V_ACTIVE < VS_START && VS_START < VS_END && VS_END <= V_TOTAL &&
          H_ACTIVE > 0 && V_ACTIVE > 0 && H_TOTAL <= 512 && V_TOTAL <= 512)) begin : g_bad_params
        $error("video_timing: illegal timing parameter combination");
    end

    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0] V_ACT_M1 = 9'(V_ACTIVE - 1);
    localparam logic [8:0] HS_S     = 9'(HS_START);
    localparam logic [8:0] HS_E     = 9'(HS_END);
    localparam logic [8:0] VS_S     = 9'(VS_START);
    localparam logic [8:0] VS_E     = 9'(VS_END);

    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    logic       field_q, field_d;
    logic       hblank_q, hblank_d;
    logic       vblank_q, vblank_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       line_start_q, line_start_d;
    logic       vbl_start_q, vbl_start_d;
    logic       h_wrap, v_wrap;

    always_comb begin
        h_wrap = (hcnt_q == H_LAST);
        v_wrap = (vcnt_q == V_LAST);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (PIX_CE) begin
            hcnt_d = h_wrap ? 9'd0 : hcnt_q + 9'd1;
            if (h_wrap) begin
                vcnt_d = v_wrap ? 9'd0 : vcnt_q + 9'd1;
            end
        end
        field_d      = field_q ^ (PIX_CE & h_wrap & v_wrap);
        line_start_d = PIX_CE & h_wrap;
        vbl_start_d  = PIX_CE & h_wrap & (vcnt_q == V_ACT_M1);
        // Decode the next counter values so levels land on the same edge as the counters.
        hblank_d = (hcnt_d >= H_ACT);
        hsync_d  = (hcnt_d >= HS_S) && (hcnt_d < HS_E);
        vblank_d = (vcnt_d >= V_ACT);
        vsync_d  = (vcnt_d >= VS_S) && (vcnt_d < VS_E);
    end

    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            field_q      <= 1'b0;
            hblank_q     <= 1'b0;
            vblank_q     <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            line_start_q <= 1'b0;
            vbl_start_q  <= 1'b0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            field_q      <= field_d;
            hblank_q     <= hblank_d;
            vblank_q     <= vblank_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            line_start_q <= line_start_d;
            vbl_start_q  <= vbl_start_d;
        end
    end

    assign HCNT       = hcnt_q;
    assign VCNT       = vcnt_q;
    assign HBLANK     = hblank_q;
    assign VBLANK     = vblank_q;
    assign HSYNC      = hsync_q;
    assign VSYNC      = vsync_q;
    assign LINE_START = line_start_q;
    assign VBL_START  = vbl_start_q;
    assign FIELD      = field_q;

endmodule
